// File: rtl/mult32_seq.sv
// Sequential 32x32 shift-and-add multiplier built around a single 32-bit adder.
// Optional signed mode (sgn port and FIX state) is enabled by defining MULT32_SIGNED_MUL_EN.
`timescale 1ns/1ps

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'h0, cin};
endmodule

module mult32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] lt,
    input  logic [31:0] rt,
`ifdef MULT32_SIGNED_MUL_EN
    input  logic        sgn,
`endif
    output logic        busy,
    output logic        done,
    output logic [63:0] p
);

`ifdef MULT32_SIGNED_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t      st;
    logic [31:0] mc;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic [31:0] addend;
    logic [31:0] sum;
    logic        cout;
    logic [31:0] lt_mag;
    logic [31:0] rt_mag;

`ifdef MULT32_SIGNED_MUL_EN
    logic        signed_op;
    logic        neg;

    // Operands enter the datapath as magnitudes; 32'h8000_0000 maps to itself.
    assign lt_mag = (sgn && lt[31]) ? (~lt + 32'd1) : lt;
    assign rt_mag = (sgn && rt[31]) ? (~rt + 32'd1) : rt;
`else
    assign lt_mag = lt;
    assign rt_mag = rt;
`endif

    assign addend = acc[0] ? mc : 32'h0;
    assign p      = acc;

    adder32 u_add (
        .a    (acc[63:32]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            mc   <= 32'h0;
            acc  <= 64'h0;
            cnt  <= 5'd0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef MULT32_SIGNED_MUL_EN
            signed_op <= 1'b0;
            neg       <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        mc   <= lt_mag;
                        acc  <= {32'h0, rt_mag};
                        cnt  <= 5'd0;
                        busy <= 1'b1;
                        st   <= CALC;
`ifdef MULT32_SIGNED_MUL_EN
                        signed_op <= sgn;
                        neg       <= sgn & (lt[31] ^ rt[31]);
`endif
                    end
                end
                CALC: begin
                    // Carry-out lands in acc[63] so no partial product bit is lost.
                    acc <= {cout, sum, acc[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
`ifdef MULT32_SIGNED_MUL_EN
                        if (signed_op) begin
                            st <= FIX;
                        end else begin
                            st   <= DONE;
                            done <= 1'b1;
                        end
`else
                        st   <= DONE;
                        done <= 1'b1;
`endif
                    end
                end
`ifdef MULT32_SIGNED_MUL_EN
                FIX: begin
                    if (neg) begin
                        acc <= ~acc + 64'd1;
                    end
                    st   <= DONE;
                    done <= 1'b1;
                end
`endif
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: begin
                    st   <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult32_seq.sv
// Randomized self-checking bench for mult32_seq against a plain arithmetic product model.
// Signed-mode cases are exercised when MULT32_SIGNED_MUL_EN is defined.
`timescale 1ns/1ps

module tb_mult32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] lt = 32'h0;
    logic [31:0] rt = 32'h0;
`ifdef MULT32_SIGNED_MUL_EN
    logic        sgn = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [63:0] p;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mult32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .lt    (lt),
        .rt    (rt),
`ifdef MULT32_SIGNED_MUL_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: exact product of the (optionally sign-extended) operands, modulo 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int          k;
        int          lat_exp;
        logic [63:0] exp;
        exp     = ref_mul(a, b, s);
        lat_exp = s ? 34 : 33;
        @(negedge clk);
        lt    = a;
        rt    = b;
        start = 1'b1;
`ifdef MULT32_SIGNED_MUL_EN
        sgn   = s;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        lt    = $urandom;
        rt    = $urandom;
        check({tag, " busy_rise"}, {63'h0, busy}, 64'h1);
        k = 1;
        while (!done && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(lat_exp));
        check({tag, " product"}, p, exp);
        @(posedge clk);
        #1;
        check({tag, " busy_done_fall"}, {62'h0, busy, done}, 64'h0);
        $display("%s: %h x %h sgn=%0b -> p=%h (expected %h) latency=%0d", tag, a, b, s, p, exp, k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          k;
        int          done_seen;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        check("in_reset outputs", {busy, done, p}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle busy", {63'h0, busy}, 64'h0);
        check("idle done", {63'h0, done}, 64'h0);
        check("idle p", p, 64'h0);

        // Basic product, then result must hold while idle
        run_mul(32'd3, 32'd5, 1'b0, "3x5");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("3x5 hold", p, 64'hF);
        end

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max x max");
        run_mul(32'h0, 32'hDEAD_BEEF, 1'b0, "zero x b");
        run_mul(32'hCAFE_F00D, 32'h1, 1'b0, "a x one");
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b0, "msb x msb");

        // Continuous start: one result per 34 cycles, DONE-cycle start ignored
        @(negedge clk);
        lt    = 32'd2;
        rt    = 32'd7;
        start = 1'b1;
        k = 0;
        while (!done && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("stream first done", {63'h0, done}, 64'h1);
        for (int r = 0; r < 2; r++) begin
            check("stream product", p, 64'd14);
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
                if (k == 1) check("stream done-cycle start ignored", {63'h0, busy}, 64'h0);
                if (k == 5) begin
                    lt = $urandom;
                    rt = $urandom;
                end
                if (k == 12) begin
                    lt = 32'd2;
                    rt = 32'd7;
                end
            end while (!done && k < 80);
            check("stream interval", 64'(k), 64'd34);
            $display("stream round %0d: p=%h interval=%0d", r, p, k);
        end
        start = 1'b0;
        check("stream last product", p, 64'd14);
        @(posedge clk);
        #1;
        check("stream idle after", {62'h0, busy, done}, 64'h0);

        // Reset asserted mid-calculation aborts without done
        @(negedge clk);
        lt    = 32'hDEAD_BEEF;
        rt    = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort outputs", {busy, done, p}, 66'h0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort no done", 64'(done_seen), 64'h0);
        $display("abort: reset during CALC, done/busy activity after = %0d", done_seen);
        run_mul(32'd6, 32'd7, 1'b0, "6x7 after reset");

`ifdef MULT32_SIGNED_MUL_EN
        run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, "signed -3x5");
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, "signed min x min");
        run_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "signed max x min");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "unsigned in signed build");
`endif

        // Randomized operands
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'b0;
`ifdef MULT32_SIGNED_MUL_EN
            s = 1'($urandom_range(0, 1));
`endif
            run_mul(a, b, s, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
